// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and types for the six-digit multiplexed 7-segment scan driver.
// Segment codes are active-high {g,f,e,d,c,b,a}; pin polarity is applied in the top.
package seg7_scan_driver_pkg;

    localparam int DIG_NUM = 6;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [2:0] IDX_SEC_L = 3'd0;
    localparam logic [2:0] IDX_SEC_H = 3'd1;
    localparam logic [2:0] IDX_MIN_L = 3'd2;
    localparam logic [2:0] IDX_MIN_H = 3'd3;
    localparam logic [2:0] IDX_HR_L  = 3'd4;
    localparam logic [2:0] IDX_HR_H  = 3'd5;

    typedef struct packed {
        logic [3:0] hr_h;
        logic [3:0] hr_l;
        logic [3:0] min_h;
        logic [3:0] min_l;
        logic [3:0] sec_h;
        logic [3:0] sec_l;
    } digits_t;

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// Combinational BCD to 7-segment decoder; non-decimal codes show a dash.
module seg7_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes six stopwatch BCD digits onto one 7-segment bus with
// frame-consistent snapshot, anti-ghost blank window and hour zero blanking.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV       = 16'd50000,
    parameter logic [15:0] BLANK_CYC      = 16'd500,
    parameter logic        SEG_ACTIVE_LOW = 1'b1,
    parameter logic        DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] hr_h,
    input  logic [3:0] hr_l,
    input  logic [3:0] min_h,
    input  logic [3:0] min_l,
    input  logic [3:0] sec_h,
    input  logic [3:0] sec_l,
    input  logic       blank_lead,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig_sel,
    output logic       frame_done
);

    localparam int               CNT_W    = (SCAN_DIV > 16'd1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 16'd1);
    localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYC);
    localparam logic [6:0]       SEG_IDLE = {7{SEG_ACTIVE_LOW}};
    localparam logic             DP_IDLE  = SEG_ACTIVE_LOW;
    localparam logic [5:0]       DIG_IDLE = {DIG_NUM{DIG_ACTIVE_LOW}};

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    digits_t          snap;
    logic             init;
    logic             tick;
    logic             last_slot;
    logic             load;

    assign tick      = (cnt == CNT_MAX);
    assign last_slot = (idx == IDX_HR_H);
    assign load      = init | (tick & last_slot);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            idx  <= '0;
            init <= 1'b1;
            snap <= '0;
        end else begin
            init <= 1'b0;
            cnt  <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= last_slot ? 3'd0 : idx + 3'd1;
            end
            if (load) begin
                snap <= '{hr_h: hr_h, hr_l: hr_l, min_h: min_h,
                          min_l: min_l, sec_h: sec_h, sec_l: sec_l};
            end
        end
    end

    // Stage p0: select digit, decode, blanking and digit enable
    logic [3:0] digit_p0;
    logic       blank_p0;
    logic [6:0] dec_seg_p0;
    logic [6:0] seg_on_p0;
    logic       dp_on_p0;
    logic [5:0] dig_on_p0;

    always_comb begin
        digit_p0 = snap.sec_l;
        case (idx)
            IDX_SEC_L: digit_p0 = snap.sec_l;
            IDX_SEC_H: digit_p0 = snap.sec_h;
            IDX_MIN_L: digit_p0 = snap.min_l;
            IDX_MIN_H: digit_p0 = snap.min_h;
            IDX_HR_L:  digit_p0 = snap.hr_l;
            IDX_HR_H:  digit_p0 = snap.hr_h;
            default:   digit_p0 = snap.sec_l;
        endcase
    end

    seg7_decode u_decode (
        .bcd (digit_p0),
        .seg (dec_seg_p0)
    );

    always_comb begin
        blank_p0 = 1'b0;
        if (blank_lead) begin
            if (idx == IDX_HR_H && snap.hr_h == 4'd0) begin
                blank_p0 = 1'b1;
            end
            if (idx == IDX_HR_L && snap.hr_h == 4'd0 && snap.hr_l == 4'd0) begin
                blank_p0 = 1'b1;
            end
        end
        seg_on_p0 = blank_p0 ? SEG_OFF : dec_seg_p0;
        dp_on_p0  = !blank_p0 && (idx == IDX_MIN_L || idx == IDX_HR_L);
        dig_on_p0 = (cnt >= BLANK_C) ? (6'd1 << idx) : 6'd0;
    end

    // Stage p1: registered pins with polarity folded in
    logic [6:0] seg_p1;
    logic       dp_p1;
    logic [5:0] dig_sel_p1;
    logic       frame_done_p1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg_p1        <= SEG_IDLE;
            dp_p1         <= DP_IDLE;
            dig_sel_p1    <= DIG_IDLE;
            frame_done_p1 <= 1'b0;
        end else begin
            seg_p1        <= seg_on_p0 ^ SEG_IDLE;
            dp_p1         <= dp_on_p0 ^ DP_IDLE;
            dig_sel_p1    <= dig_on_p0 ^ DIG_IDLE;
            frame_done_p1 <= tick & last_slot;
        end
    end

    assign seg        = seg_p1;
    assign dp         = dp_p1;
    assign dig_sel    = dig_sel_p1;
    assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYC=2, active-low pins.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] hr_h = 4'd0, hr_l = 4'd0, min_h = 4'd0, min_l = 4'd0, sec_h = 4'd0, sec_l = 4'd0;
    logic       blank_lead = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig_sel;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int n = 0;

    logic [6:0] exp_seg [6];
    logic       exp_dp  [6];

    seg7_scan_driver #(
        .SCAN_DIV       (16'd8),
        .BLANK_CYC      (16'd2),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hr_h       (hr_h),
        .hr_l       (hr_l),
        .min_h      (min_h),
        .min_l      (min_l),
        .sec_h      (sec_h),
        .sec_l      (sec_l),
        .blank_lead (blank_lead),
        .seg        (seg),
        .dp         (dp),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Pin state after edge n reflects scan state s = n-1: slot (s/8)%6, count s%8.
    function automatic logic [5:0] exp_dig(int s);
        logic [5:0] one;
        one = 6'd1 << ((s / 8) % 6);
        return ((s % 8) >= 2) ? ~one : 6'h3F;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    task automatic align_frame();
        step();
        while (n % 48 != 0) step();
    endtask

    task automatic set_digits(input logic [3:0] a, b, c, d, e, f);
        hr_h = a; hr_l = b; min_h = c; min_l = d; sec_h = e; sec_l = f;
    endtask

    task automatic load_exp_123456();
        exp_seg[0] = 7'h02; exp_dp[0] = 1'b1;
        exp_seg[1] = 7'h12; exp_dp[1] = 1'b1;
        exp_seg[2] = 7'h19; exp_dp[2] = 1'b0;
        exp_seg[3] = 7'h30; exp_dp[3] = 1'b1;
        exp_seg[4] = 7'h24; exp_dp[4] = 1'b0;
        exp_seg[5] = 7'h79; exp_dp[5] = 1'b1;
    endtask

    task automatic test_reset();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
        checks++; if (dig_sel !== 6'h3F) begin errors++; $display("FAIL reset_dig got %h want 3f", dig_sel); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
        rstn = 1'b1;
        n = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (dig_sel !== 6'h3F) begin errors++; $display("FAIL post_reset_dig n=%0d got %h want 3f", n, dig_sel); end
            checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL post_reset_fd n=%0d got %b want 0", n, frame_done); end
        end
    endtask

    task automatic test_scan();
        int on_cnt [6];
        logic [5:0] ed;
        int s;
        load_exp_123456();
        for (int b = 0; b < 6; b++) on_cnt[b] = 0;
        while (n < 96) begin
            step();
            s = n - 1;
            ed = exp_dig(s);
            checks++; if (dig_sel !== ed) begin errors++; $display("FAIL scan_dig n=%0d got %h want %h", n, dig_sel, ed); end
            if (ed != 6'h3F) begin
                checks++; if (seg !== exp_seg[(s/8)%6]) begin errors++; $display("FAIL scan_seg n=%0d got %h want %h", n, seg, exp_seg[(s/8)%6]); end
                checks++; if (dp !== exp_dp[(s/8)%6]) begin errors++; $display("FAIL scan_dp n=%0d got %b want %b", n, dp, exp_dp[(s/8)%6]); end
            end
            checks++; if (frame_done !== (s % 48 == 47)) begin errors++; $display("FAIL scan_fd n=%0d got %b want %b", n, frame_done, (s % 48 == 47)); end
            if (s >= 48 && s < 96) begin
                for (int b = 0; b < 6; b++) if (dig_sel[b] === 1'b0) on_cnt[b]++;
            end
        end
        for (int b = 0; b < 6; b++) begin
            checks++; if (on_cnt[b] != 6) begin errors++; $display("FAIL scan_duty bit%0d got %0d want 6", b, on_cnt[b]); end
        end
    endtask

    task automatic test_snapshot();
        logic [5:0] ed;
        int s;
        int base;
        load_exp_123456();
        base = n;
        repeat (96) begin
            step();
            s = n - 1;
            if (s == base + 48) begin
                exp_seg[0] = 7'h78;
                exp_seg[3] = 7'h00;
            end
            ed = exp_dig(s);
            checks++; if (dig_sel !== ed) begin errors++; $display("FAIL snap_dig n=%0d got %h want %h", n, dig_sel, ed); end
            if (ed != 6'h3F) begin
                checks++; if (seg !== exp_seg[(s/8)%6]) begin errors++; $display("FAIL snap_seg n=%0d got %h want %h", n, seg, exp_seg[(s/8)%6]); end
            end
            if (s == base + 2*8 + 3) begin
                sec_l = 4'd7;
                min_h = 4'd8;
            end
        end
    endtask

    task automatic test_blank_lead();
        logic [5:0] ed;
        int s;
        set_digits(4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd9);
        blank_lead = 1'b1;
        exp_seg[0] = 7'h10; exp_dp[0] = 1'b1;
        exp_seg[1] = 7'h40; exp_dp[1] = 1'b1;
        exp_seg[2] = 7'h12; exp_dp[2] = 1'b0;
        exp_seg[3] = 7'h40; exp_dp[3] = 1'b1;
        exp_seg[4] = 7'h7F; exp_dp[4] = 1'b1;
        exp_seg[5] = 7'h7F; exp_dp[5] = 1'b1;
        align_frame();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                blank_lead = 1'b0;
                exp_seg[4] = 7'h40; exp_dp[4] = 1'b0;
                exp_seg[5] = 7'h40; exp_dp[5] = 1'b1;
            end
            repeat (48) begin
                step();
                s = n - 1;
                ed = exp_dig(s);
                checks++; if (dig_sel !== ed) begin errors++; $display("FAIL blank_dig n=%0d got %h want %h", n, dig_sel, ed); end
                if (ed != 6'h3F) begin
                    checks++; if (seg !== exp_seg[(s/8)%6]) begin errors++; $display("FAIL blank_seg lead=%b n=%0d got %h want %h", blank_lead, n, seg, exp_seg[(s/8)%6]); end
                    checks++; if (dp !== exp_dp[(s/8)%6]) begin errors++; $display("FAIL blank_dp lead=%b n=%0d got %b want %b", blank_lead, n, dp, exp_dp[(s/8)%6]); end
                end
            end
        end
    endtask

    task automatic test_dash();
        logic [5:0] ed;
        int s;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'hB, 4'd6);
        load_exp_123456();
        exp_seg[1] = 7'h3F;
        align_frame();
        repeat (48) begin
            step();
            s = n - 1;
            ed = exp_dig(s);
            checks++; if (dig_sel !== ed) begin errors++; $display("FAIL dash_dig n=%0d got %h want %h", n, dig_sel, ed); end
            if (ed != 6'h3F) begin
                checks++; if (seg !== exp_seg[(s/8)%6]) begin errors++; $display("FAIL dash_seg n=%0d got %h want %h", n, seg, exp_seg[(s/8)%6]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] ed;
        int s;
        int base;
        base = n;
        while (n - 1 != base + 3*8 + 5) step();
        rstn = 1'b0;
        #1;
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL midrst_seg got %h want 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL midrst_dp got %b want 1", dp); end
        checks++; if (dig_sel !== 6'h3F) begin errors++; $display("FAIL midrst_dig got %h want 3f", dig_sel); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_fd got %b want 0", frame_done); end
        set_digits(4'd2, 4'd1, 4'd4, 4'd3, 4'd0, 4'd7);
        exp_seg[0] = 7'h78; exp_dp[0] = 1'b1;
        exp_seg[1] = 7'h40; exp_dp[1] = 1'b1;
        exp_seg[2] = 7'h30; exp_dp[2] = 1'b0;
        exp_seg[3] = 7'h19; exp_dp[3] = 1'b1;
        exp_seg[4] = 7'h79; exp_dp[4] = 1'b0;
        exp_seg[5] = 7'h24; exp_dp[5] = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        n = 0;
        repeat (48) begin
            step();
            s = n - 1;
            ed = exp_dig(s);
            checks++; if (dig_sel !== ed) begin errors++; $display("FAIL restart_dig n=%0d got %h want %h", n, dig_sel, ed); end
            if (ed != 6'h3F) begin
                checks++; if (seg !== exp_seg[(s/8)%6]) begin errors++; $display("FAIL restart_seg n=%0d got %h want %h", n, seg, exp_seg[(s/8)%6]); end
                checks++; if (dp !== exp_dp[(s/8)%6]) begin errors++; $display("FAIL restart_dp n=%0d got %b want %b", n, dp, exp_dp[(s/8)%6]); end
            end
            checks++; if (frame_done !== (s == 47)) begin errors++; $display("FAIL restart_fd n=%0d got %b want %b", n, frame_done, (s == 47)); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_blank_lead();
        test_dash();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
